// File: rtl/latency_decoding.sv
// ---------------------------------------------------------------------------
// latency_decoding
//
// Purpose:
//   Inverse of the latency (time-to-first-spike) encoder. During a window of
//   T_WINDOW accepted spike vectors it records the first timestep at which
//   each neuron fires. After the window it streams one decoded intensity per
//   neuron, in index order: an earlier first spike gives a larger value,
//   (T_WINDOW-1 - t_first) * SCALE >> SHIFT, saturated to DATA_W bits.
//   A neuron that never fired decodes to 0 with out_nospk set.
//
// Ports:
//   clk        in   rising-edge clock for all logic
//   reset      in   synchronous, active-high; aborts any window in progress
//   start      in   begins a window (only looked at while idle)
//   spk_valid  in   spike vector valid
//   spk_ready  out  decoder accepts a spike vector (window collection only)
//   spk_vec    in   bit i = neuron i spiked in this timestep
//   out_valid  out  decoded value valid
//   out_ready  in   downstream accepts the decoded value
//   out_idx    out  neuron index of out_data
//   out_data   out  decoded value
//   out_nospk  out  neuron never spiked in the window (out_data is 0)
//   busy       out  decoder is not idle
//   done       out  one-cycle pulse after the last value is accepted
//
// Configuration:
//   LATENCY_DECODE_EARLY_TERM_EN  when defined, the window ends as soon as
//   every neuron has spiked instead of always consuming T_WINDOW beats.
// ---------------------------------------------------------------------------
module latency_decoding #(
  parameter int N_NEURONS = 16,
  parameter int T_WINDOW  = 32,
  parameter int DATA_W    = 8,
  parameter int SCALE     = 263,
  parameter int SCALE_W   = 16,
  parameter int SHIFT     = 5
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         spk_valid,
  output logic                         spk_ready,
  input  logic [N_NEURONS-1:0]         spk_vec,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(N_NEURONS)-1:0] out_idx,
  output logic [DATA_W-1:0]            out_data,
  output logic                         out_nospk,
  output logic                         busy,
  output logic                         done
);

  localparam int T_W    = $clog2(T_WINDOW);
  localparam int IDX_W  = $clog2(N_NEURONS);
  localparam int PROD_W = T_W + SCALE_W;

  localparam logic [T_W-1:0]    LAST_T   = T_W'(T_WINDOW - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NEURONS - 1);
  localparam logic [PROD_W-1:0] OUT_MAX  = PROD_W'((1 << DATA_W) - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_MUL   = 2'd2;
  localparam logic [1:0] S_OUT   = 2'd3;

  logic [1:0]           state;
  logic [N_NEURONS-1:0] seen;
  logic [T_W-1:0]       t_first [N_NEURONS];
  logic [T_W-1:0]       t_cnt;
  logic [IDX_W-1:0]     idx;
  logic [PROD_W-1:0]    prod;
  logic [T_W-1:0]       remain;
  logic [PROD_W-1:0]    shifted;
  logic                 all_seen;

  // Early termination looks at the table as it will be after this beat, so
  // the window can close on the very beat that makes the last neuron fire.
`ifdef LATENCY_DECODE_EARLY_TERM_EN
  assign all_seen = &(seen | spk_vec);
`else
  assign all_seen = 1'b0;
`endif

  // Time remaining in the window after the first spike of the neuron being
  // decoded; larger means the neuron fired earlier.
  assign remain  = LAST_T - t_first[idx];
  assign shifted = prod >> SHIFT;

  assign spk_ready = (state == S_ACCUM);
  assign busy      = (state != S_IDLE);
  assign out_valid = (state == S_OUT);
  assign out_idx   = idx;

  // prod, idx and seen are all frozen while in OUT, so the outputs stay
  // stable for as long as downstream stalls.
  always_comb begin
    out_data  = '0;
    out_nospk = 1'b0;
    if (state == S_OUT) begin
      if (seen[idx]) begin
        out_data = (shifted > OUT_MAX) ? '1 : shifted[DATA_W-1:0];
      end else begin
        out_nospk = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      seen  <= '0;
      t_cnt <= '0;
      idx   <= '0;
      prod  <= '0;
      done  <= 1'b0;
      for (int i = 0; i < N_NEURONS; i++) begin
        t_first[i] <= '0;
      end
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_ACCUM;
            seen  <= '0;
            t_cnt <= '0;
            idx   <= '0;
          end
        end
        S_ACCUM: begin
          // Timesteps only advance on accepted beats; only the first spike
          // of each neuron is recorded.
          if (spk_valid) begin
            for (int i = 0; i < N_NEURONS; i++) begin
              if (spk_vec[i] && !seen[i]) begin
                t_first[i] <= t_cnt;
              end
            end
            seen  <= seen | spk_vec;
            t_cnt <= t_cnt + 1'b1;
            if ((t_cnt == LAST_T) || all_seen) begin
              state <= S_MUL;
              idx   <= '0;
            end
          end
        end
        S_MUL: begin
          prod  <= PROD_W'(remain) * PROD_W'(SCALE);
          state <= S_OUT;
        end
        S_OUT: begin
          if (out_ready) begin
            if (idx == LAST_IDX) begin
              state <= S_IDLE;
              idx   <= '0;
              done  <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              state <= S_MUL;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_latency_decoding.sv
// ---------------------------------------------------------------------------
// tb_latency_decoding
//
// Directed bench for latency_decoding with default parameters (16 neurons,
// 32-step window, SCALE 263, SHIFT 5). Expected decoded values are worked
// out by hand from (31 - t_first) * 263 >> 5:
//   t=0 -> 254, t=2 -> 238, t=3 -> 230, t=15 -> 131, t=31 -> 0.
// ---------------------------------------------------------------------------
module tb_latency_decoding;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        spk_valid;
  logic        spk_ready;
  logic [15:0] spk_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic [7:0]  out_data;
  logic        out_nospk;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int beatCount = 0;
  int doneCount = 0;

  int firstT   [16];
  int secondT  [16];
  int expData  [16];
  int expNospk [16];

  latency_decoding dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .spk_valid (spk_valid),
    .spk_ready (spk_ready),
    .spk_vec   (spk_vec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_idx   (out_idx),
    .out_data  (out_data),
    .out_nospk (out_nospk),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Independent tally of accepted spike beats and done pulses.
  always @(posedge clk) begin
    if (!reset && spk_valid && spk_ready) beatCount++;
    if (done) doneCount++;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
  endtask

  function automatic logic [15:0] vecAt(input int t);
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < 16; i++) begin
      if (firstT[i] == t || secondT[i] == t) v[i] = 1'b1;
    end
    return v;
  endfunction

  task automatic clearPattern();
    for (int i = 0; i < 16; i++) begin
      firstT[i]   = -1;
      secondT[i]  = -1;
      expData[i]  = 0;
      expNospk[i] = 1;
    end
  endtask

  task automatic setSpike(input int n, input int t, input int value);
    firstT[n]   = t;
    expData[n]  = value;
    expNospk[n] = 0;
  endtask

  // Start a window and feed nBeats spike vectors, with gap idle cycles
  // (carrying a junk all-ones vector) before each beat.
  task automatic applyStimulus(input int gap, input int nBeats);
    beatCount = 0;
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1);
    for (int t = 0; t < nBeats; t++) begin
      for (int g = 0; g < gap; g++) begin
        spk_valid = 1'b0;
        spk_vec   = '1;
        step();
      end
      spk_valid = 1'b1;
      spk_vec   = vecAt(t);
      checkOutput("spk_ready_accum", spk_ready, 1);
      step();
    end
    // Keep offering beats; none may be taken once the window has closed.
    spk_valid = 1'b1;
    spk_vec   = '1;
  endtask

  task automatic collectOutputs(input int holdIdx, input int abortIdx);
    int waitCnt;
    logic [3:0] heldIdx;
    logic [7:0] heldData;
    for (int k = 0; k < 16; k++) begin
      out_ready = (k != holdIdx);
      waitCnt = 0;
      while (!out_valid && waitCnt < 8) begin
        step();
        waitCnt++;
      end
      if (!out_valid) begin
        checkOutput("out_valid_timeout", out_valid, 1);
        return;
      end
      checkOutput($sformatf("out_idx_%0d", k), out_idx, k);
      checkOutput($sformatf("out_data_%0d", k), out_data, expData[k]);
      checkOutput($sformatf("out_nospk_%0d", k), out_nospk, expNospk[k]);
      if (k == abortIdx) begin
        out_ready = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        checkOutput("abort_out_valid", out_valid, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_out_data", out_data, 0);
        return;
      end
      if (k == holdIdx) begin
        heldIdx  = out_idx;
        heldData = out_data;
        for (int h = 0; h < 5; h++) begin
          step();
          checkOutput("hold_out_valid", out_valid, 1);
          checkOutput("hold_out_idx", out_idx, heldIdx);
          checkOutput("hold_out_data", out_data, heldData);
        end
        out_ready = 1'b1;
      end
      step();
      if (k < 15) begin
        checkOutput("mul_gap_out_valid", out_valid, 0);
        checkOutput("done_early", done, 0);
      end else begin
        checkOutput("done_pulse", done, 1);
        checkOutput("busy_after_last", busy, 0);
      end
    end
    step();
    checkOutput("done_one_cycle", done, 0);
  endtask

  // Full window: exactly 32 beats, first value two cycles after the last one.
  task automatic windowRun(input int gap, input int holdIdx, input int abortIdx);
    applyStimulus(gap, 32);
    checkOutput("spk_ready_after_window", spk_ready, 0);
    checkOutput("out_valid_in_mul", out_valid, 0);
    checkOutput("beats_consumed", beatCount, 32);
    collectOutputs(holdIdx, abortIdx);
    checkOutput("beats_after_emit", beatCount, 32);
    spk_valid = 1'b0;
    spk_vec   = '0;
  endtask

  initial begin
    int doneBefore;
    reset     = 1'b1;
    start     = 1'b0;
    spk_valid = 1'b0;
    spk_vec   = '0;
    out_ready = 1'b0;
    clearPattern();
    step();
    step();
    reset = 1'b0;

    $display("[TB] reset and idle");
    checkOutput("rst_spk_ready", spk_ready, 0);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_idx", out_idx, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_nospk", out_nospk, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_done", done, 0);
    beatCount = 0;
    for (int c = 0; c < 10; c++) begin
      spk_valid = 1'b1;
      spk_vec   = 16'($urandom);
      step();
      checkOutput("idle_spk_ready", spk_ready, 0);
      checkOutput("idle_out_valid", out_valid, 0);
      checkOutput("idle_busy", busy, 0);
      checkOutput("idle_done", done, 0);
    end
    checkOutput("idle_no_beats", beatCount, 0);
    spk_valid = 1'b0;
    out_ready = 1'b1;

    $display("[TB] window A: t=0/15/31, hold on idx 4");
    clearPattern();
    setSpike(0, 0, 254);
    setSpike(1, 15, 131);
    setSpike(2, 31, 0);
    doneBefore = doneCount;
    windowRun(0, 4, -1);
    checkOutput("done_count_A", doneCount, doneBefore + 1);

    $display("[TB] window B: neuron 5 spikes at t=3 and t=10");
    clearPattern();
    setSpike(5, 3, 230);
    secondT[5] = 10;
    setSpike(15, 0, 254);
    setSpike(0, 31, 0);
    windowRun(0, -1, -1);

    $display("[TB] window B gapped, beat every 3rd cycle");
    windowRun(2, -1, -1);

    $display("[TB] reset in ACCUM at t=10");
    doneBefore = doneCount;
    applyStimulus(0, 10);
    checkOutput("accum_busy_t10", busy, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    checkOutput("accum_abort_busy", busy, 0);
    checkOutput("accum_abort_spk_ready", spk_ready, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("accum_abort_no_accept", spk_ready, 0);
      checkOutput("accum_abort_out_valid", out_valid, 0);
    end
    checkOutput("accum_abort_beats", beatCount, 10);
    spk_valid = 1'b0;

    $display("[TB] reset in OUT at idx 7");
    clearPattern();
    setSpike(0, 0, 254);
    setSpike(1, 15, 131);
    setSpike(2, 31, 0);
    applyStimulus(0, 32);
    spk_valid = 1'b0;
    collectOutputs(-1, 7);
    for (int c = 0; c < 3; c++) begin
      step();
      checkOutput("out_abort_out_valid", out_valid, 0);
      checkOutput("out_abort_busy", busy, 0);
    end
    checkOutput("out_abort_no_done", doneCount, doneBefore);
    out_ready = 1'b1;

    $display("[TB] all neurons spike at t=2");
    clearPattern();
    for (int i = 0; i < 16; i++) setSpike(i, 2, 238);
`ifdef LATENCY_DECODE_EARLY_TERM_EN
    applyStimulus(0, 3);
    checkOutput("early_spk_ready", spk_ready, 0);
    checkOutput("early_busy", busy, 1);
    checkOutput("early_beats", beatCount, 3);
    collectOutputs(-1, -1);
    checkOutput("early_beats_after", beatCount, 3);
    spk_valid = 1'b0;
`else
    windowRun(0, -1, -1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
